// File: rtl/ndarray_window_pkg.sv
// ndarray_window_pkg: shared sizing, state encoding and configuration check for the window feeder.
package ndarray_window_pkg;
    localparam int ELEM_W    = 2;
    localparam int ROW_LEN   = 3;
    localparam int DEPTH     = 6;
    localparam int SEL_W     = 2;
    localparam int CNT_W     = 8;
    localparam int ROW_W     = ROW_LEN * ELEM_W;
    localparam int FRAME_W   = DEPTH * ROW_W;
    localparam int NUM_OFF   = 2 ** SEL_W;
    localparam int ROW_CNT_W = $clog2(DEPTH);

    typedef enum logic {FILL, SWEEP} state_t;

    // Every window offset must leave at least one row below it inside the frame.
    function automatic bit offsets_fit();
        return NUM_OFF <= DEPTH - 1;
    endfunction
endpackage

// File: rtl/ndarray_window_feeder_if.sv
// ndarray_window_feeder_if: row input, window output and flush signals of the feeder.
interface ndarray_window_feeder_if;
    import ndarray_window_pkg::*;
    logic               flush;
    logic               in_valid;
    logic               in_ready;
    logic [ROW_W-1:0]   in_row;
    logic               out_valid;
    logic               out_ready;
    logic [FRAME_W-1:0] out_rows;
    logic [SEL_W-1:0]   out_sel;
    logic               out_last;
    logic [CNT_W-1:0]   frames_done;

    modport master (
        output flush, in_valid, in_row, out_ready,
        input  in_ready, out_valid, out_rows, out_sel, out_last, frames_done
    );
    modport slave (
        input  flush, in_valid, in_row, out_ready,
        output in_ready, out_valid, out_rows, out_sel, out_last, frames_done
    );
endinterface

// File: rtl/ndarray_row_store.sv
// ndarray_row_store: DEPTH x ROW_W register array exposing the whole frame, row 0 in the low bits.
module ndarray_row_store
    import ndarray_window_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_we,
    input  logic [ROW_CNT_W-1:0] i_idx,
    input  logic [ROW_W-1:0]     i_data,
    output logic [FRAME_W-1:0]   o_frame
);
    logic [DEPTH-1:0][ROW_W-1:0] r_mem;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_mem <= '0;
        else if (i_we)
            r_mem[i_idx] <= i_data;
    end

    assign o_frame = r_mem;
endmodule

// File: rtl/ndarray_window_feeder.sv
// ndarray_window_feeder: buffers a DEPTH-row frame, then sweeps window offsets 0..NUM_OFF-1
// over it with a valid/ready handshake before accepting the next frame.
module ndarray_window_feeder
    import ndarray_window_pkg::*;
(
    input  logic                   CLK,
    input  logic                   ASYNCRESET,
    ndarray_window_feeder_if.slave io_bus
);
    state_t               r_state, w_state_nx;
    logic [ROW_CNT_W-1:0] r_row_cnt, w_row_cnt_nx;
    logic [SEL_W-1:0]     r_sel, w_sel_nx;
    logic [CNT_W-1:0]     r_frames, w_frames_nx;
    logic                 w_fill, w_last, w_row_last, w_wr;

    if (!offsets_fit()) begin : g_bad_cfg
        $error("ndarray_window_feeder: NUM_OFF must not exceed DEPTH-1");
    end

    assign w_fill     = r_state == FILL;
    assign w_last     = r_sel == SEL_W'(NUM_OFF - 1);
    assign w_row_last = r_row_cnt == ROW_CNT_W'(DEPTH - 1);
    // A row offered in the same cycle as flush is dropped.
    assign w_wr       = w_fill && io_bus.in_valid && !io_bus.flush;

    always_comb begin
        w_state_nx   = r_state;
        w_row_cnt_nx = r_row_cnt;
        w_sel_nx     = r_sel;
        w_frames_nx  = r_frames;
        if (io_bus.flush) begin
            w_state_nx   = FILL;
            w_row_cnt_nx = '0;
            w_sel_nx     = '0;
        end else if (w_fill) begin
            if (io_bus.in_valid) begin
                w_state_nx   = w_row_last ? SWEEP : FILL;
                w_row_cnt_nx = w_row_last ? '0 : r_row_cnt + 1'b1;
            end
        end else if (io_bus.out_ready) begin
            w_state_nx  = w_last ? FILL : SWEEP;
            w_sel_nx    = w_last ? '0 : r_sel + 1'b1;
            w_frames_nx = w_last ? r_frames + 1'b1 : r_frames;
        end
    end

    always_ff @(posedge CLK or posedge ASYNCRESET) begin
        if (ASYNCRESET) begin
            r_state   <= FILL;
            r_row_cnt <= '0;
            r_sel     <= '0;
            r_frames  <= '0;
        end else begin
            r_state   <= w_state_nx;
            r_row_cnt <= w_row_cnt_nx;
            r_sel     <= w_sel_nx;
            r_frames  <= w_frames_nx;
        end
    end

    ndarray_row_store u_store (
        .clk     (CLK),
        .rst     (ASYNCRESET),
        .i_we    (w_wr),
        .i_idx   (r_row_cnt),
        .i_data  (io_bus.in_row),
        .o_frame (io_bus.out_rows)
    );

    assign io_bus.in_ready    = w_fill;
    assign io_bus.out_valid   = !w_fill;
    assign io_bus.out_sel     = r_sel;
    assign io_bus.out_last    = !w_fill && w_last;
    assign io_bus.frames_done = r_frames;
endmodule

// File: tb/tb_ndarray_window_feeder.sv
// tb_ndarray_window_feeder: directed scenarios for the window feeder with hand-computed expectations.
module tb_ndarray_window_feeder;
    import ndarray_window_pkg::*;

    logic CLK = 1'b0;
    logic ASYNCRESET = 1'b1;
    int checks = 0;
    int failures = 0;

    ndarray_window_feeder_if ifc ();

    ndarray_window_feeder dut (
        .CLK        (CLK),
        .ASYNCRESET (ASYNCRESET),
        .io_bus     (ifc.slave)
    );

    always #5 CLK = ~CLK;

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [FRAME_W-1:0] frame_of(input logic [ROW_W-1:0] b);
        logic [FRAME_W-1:0] f;
        f = '0;
        for (int r = 0; r < DEPTH; r++)
            f[r*ROW_W +: ROW_W] = b + ROW_W'(r);
        return f;
    endfunction

    task automatic push_rows(input logic [ROW_W-1:0] b, input int n);
        ifc.in_valid = 1'b1;
        for (int i = 0; i < n; i++) begin
            ifc.in_row = b + ROW_W'(i);
            tick();
        end
        ifc.in_valid = 1'b0;
    endtask

    task automatic test_reset;
        ASYNCRESET = 1'b1;
        ifc.flush = 1'b0;
        ifc.in_valid = 1'b0;
        ifc.in_row = '0;
        ifc.out_ready = 1'b0;
        tick();
        tick();
        ASYNCRESET = 1'b0;
        tick();
        checks++; if (ifc.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%0h exp=1", ifc.in_ready); end
        checks++; if (ifc.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0h exp=0", ifc.out_valid); end
        checks++; if (ifc.out_sel !== 2'd0) begin failures++; $display("FAIL reset_out_sel got=%0h exp=0", ifc.out_sel); end
        checks++; if (ifc.out_last !== 1'b0) begin failures++; $display("FAIL reset_out_last got=%0h exp=0", ifc.out_last); end
        checks++; if (ifc.frames_done !== 8'd0) begin failures++; $display("FAIL reset_frames_done got=%0h exp=0", ifc.frames_done); end
        checks++; if (ifc.out_rows !== 36'h0) begin failures++; $display("FAIL reset_out_rows got=%0h exp=0", ifc.out_rows); end
    endtask

    task automatic test_basic_frame;
        ifc.out_ready = 1'b1;
        ifc.in_valid = 1'b1;
        for (int r = 0; r < DEPTH; r++) begin
            checks++; if (ifc.in_ready !== 1'b1) begin failures++; $display("FAIL basic_fill_ready r=%0d got=%0h exp=1", r, ifc.in_ready); end
            checks++; if (ifc.out_valid !== 1'b0) begin failures++; $display("FAIL basic_fill_valid r=%0d got=%0h exp=0", r, ifc.out_valid); end
            ifc.in_row = 6'(r + 1);
            tick();
        end
        ifc.in_valid = 1'b0;
        for (int s = 0; s < NUM_OFF; s++) begin
            checks++; if (ifc.out_valid !== 1'b1) begin failures++; $display("FAIL basic_sweep_valid s=%0d got=%0h exp=1", s, ifc.out_valid); end
            checks++; if (ifc.out_sel !== 2'(s)) begin failures++; $display("FAIL basic_sweep_sel got=%0h exp=%0h", ifc.out_sel, s); end
            checks++; if (ifc.out_last !== (s == NUM_OFF - 1)) begin failures++; $display("FAIL basic_sweep_last s=%0d got=%0h exp=%0h", s, ifc.out_last, s == NUM_OFF - 1); end
            checks++; if (ifc.out_rows !== frame_of(6'h01)) begin failures++; $display("FAIL basic_sweep_rows got=%0h exp=%0h", ifc.out_rows, frame_of(6'h01)); end
            checks++; if (ifc.in_ready !== 1'b0) begin failures++; $display("FAIL basic_sweep_in_ready got=%0h exp=0", ifc.in_ready); end
            tick();
        end
        checks++; if (ifc.frames_done !== 8'd1) begin failures++; $display("FAIL basic_frames_done got=%0h exp=1", ifc.frames_done); end
        checks++; if (ifc.in_ready !== 1'b1) begin failures++; $display("FAIL basic_back_to_fill got=%0h exp=1", ifc.in_ready); end
        checks++; if (ifc.out_valid !== 1'b0) begin failures++; $display("FAIL basic_valid_drop got=%0h exp=0", ifc.out_valid); end
    endtask

    task automatic test_backpressure;
        ifc.out_ready = 1'b0;
        push_rows(6'h01, DEPTH);
        ifc.out_ready = 1'b1;
        tick();
        tick();
        ifc.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (ifc.out_valid !== 1'b1) begin failures++; $display("FAIL bp_hold_valid i=%0d got=%0h exp=1", i, ifc.out_valid); end
            checks++; if (ifc.out_sel !== 2'd2) begin failures++; $display("FAIL bp_hold_sel i=%0d got=%0h exp=2", i, ifc.out_sel); end
            checks++; if (ifc.out_rows !== frame_of(6'h01)) begin failures++; $display("FAIL bp_hold_rows got=%0h exp=%0h", ifc.out_rows, frame_of(6'h01)); end
            checks++; if (ifc.frames_done !== 8'd1) begin failures++; $display("FAIL bp_hold_frames got=%0h exp=1", ifc.frames_done); end
        end
        ifc.out_ready = 1'b1;
        tick();
        checks++; if (ifc.out_sel !== 2'd3) begin failures++; $display("FAIL bp_resume_sel got=%0h exp=3", ifc.out_sel); end
        checks++; if (ifc.out_last !== 1'b1) begin failures++; $display("FAIL bp_resume_last got=%0h exp=1", ifc.out_last); end
        tick();
        checks++; if (ifc.frames_done !== 8'd2) begin failures++; $display("FAIL bp_frames_done got=%0h exp=2", ifc.frames_done); end
        checks++; if (ifc.out_valid !== 1'b0) begin failures++; $display("FAIL bp_end_valid got=%0h exp=0", ifc.out_valid); end
    endtask

    task automatic test_valid_toggle;
        for (int i = 0; i < 2 * DEPTH - 1; i++) begin
            ifc.in_valid = (i % 2 == 0);
            ifc.in_row = (i % 2 == 0) ? 6'(8'h20 + i / 2) : 6'h3F;
            tick();
        end
        checks++; if (ifc.out_valid !== 1'b1) begin failures++; $display("FAIL tog_sweep_valid got=%0h exp=1", ifc.out_valid); end
        checks++; if (ifc.out_rows !== frame_of(6'h20)) begin failures++; $display("FAIL tog_rows got=%0h exp=%0h", ifc.out_rows, frame_of(6'h20)); end
        ifc.in_valid = 1'b1;
        ifc.in_row = 6'h3F;
        ifc.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (ifc.in_ready !== 1'b0) begin failures++; $display("FAIL tog_sweep_in_ready got=%0h exp=0", ifc.in_ready); end
            checks++; if (ifc.out_rows !== frame_of(6'h20)) begin failures++; $display("FAIL tog_sweep_rows got=%0h exp=%0h", ifc.out_rows, frame_of(6'h20)); end
        end
        ifc.out_ready = 1'b1;
        repeat (NUM_OFF) tick();
        ifc.in_valid = 1'b0;
        checks++; if (ifc.frames_done !== 8'd3) begin failures++; $display("FAIL tog_frames_done got=%0h exp=3", ifc.frames_done); end
        checks++; if (ifc.out_rows !== frame_of(6'h20)) begin failures++; $display("FAIL tog_rows_after got=%0h exp=%0h", ifc.out_rows, frame_of(6'h20)); end
    endtask

    task automatic test_flush_fill;
        logic [FRAME_W-1:0] exp_rows;
        exp_rows = frame_of(6'h20);
        for (int r = 0; r < 3; r++)
            exp_rows[r*ROW_W +: ROW_W] = 6'(8'h30 + r);
        push_rows(6'h30, 3);
        ifc.flush = 1'b1;
        ifc.in_valid = 1'b1;
        ifc.in_row = 6'h3A;
        tick();
        ifc.flush = 1'b0;
        ifc.in_valid = 1'b0;
        checks++; if (ifc.in_ready !== 1'b1) begin failures++; $display("FAIL flush_fill_ready got=%0h exp=1", ifc.in_ready); end
        checks++; if (ifc.out_rows !== exp_rows) begin failures++; $display("FAIL flush_fill_storage got=%0h exp=%0h", ifc.out_rows, exp_rows); end
        checks++; if (ifc.frames_done !== 8'd3) begin failures++; $display("FAIL flush_fill_frames got=%0h exp=3", ifc.frames_done); end
        push_rows(6'h11, DEPTH);
        checks++; if (ifc.out_valid !== 1'b1) begin failures++; $display("FAIL flush_new_valid got=%0h exp=1", ifc.out_valid); end
        checks++; if (ifc.out_rows !== frame_of(6'h11)) begin failures++; $display("FAIL flush_new_rows got=%0h exp=%0h", ifc.out_rows, frame_of(6'h11)); end
        repeat (NUM_OFF) tick();
        checks++; if (ifc.frames_done !== 8'd4) begin failures++; $display("FAIL flush_new_frames got=%0h exp=4", ifc.frames_done); end
    endtask

    task automatic test_flush_last;
        ifc.out_ready = 1'b1;
        push_rows(6'h08, DEPTH);
        repeat (NUM_OFF - 1) tick();
        checks++; if (ifc.out_last !== 1'b1) begin failures++; $display("FAIL flast_pre_last got=%0h exp=1", ifc.out_last); end
        ifc.flush = 1'b1;
        tick();
        ifc.flush = 1'b0;
        checks++; if (ifc.out_valid !== 1'b0) begin failures++; $display("FAIL flast_valid got=%0h exp=0", ifc.out_valid); end
        checks++; if (ifc.in_ready !== 1'b1) begin failures++; $display("FAIL flast_in_ready got=%0h exp=1", ifc.in_ready); end
        checks++; if (ifc.out_sel !== 2'd0) begin failures++; $display("FAIL flast_sel got=%0h exp=0", ifc.out_sel); end
        checks++; if (ifc.frames_done !== 8'd4) begin failures++; $display("FAIL flast_frames got=%0h exp=4", ifc.frames_done); end
    endtask

    task automatic test_async_reset;
        ifc.out_ready = 1'b1;
        push_rows(6'h01, DEPTH);
        tick();
        checks++; if (ifc.out_sel !== 2'd1) begin failures++; $display("FAIL areset_pre_sel got=%0h exp=1", ifc.out_sel); end
        #2;
        ASYNCRESET = 1'b1;
        #1;
        checks++; if (ifc.out_valid !== 1'b0) begin failures++; $display("FAIL areset_valid got=%0h exp=0", ifc.out_valid); end
        checks++; if (ifc.out_sel !== 2'd0) begin failures++; $display("FAIL areset_sel got=%0h exp=0", ifc.out_sel); end
        checks++; if (ifc.frames_done !== 8'd0) begin failures++; $display("FAIL areset_frames got=%0h exp=0", ifc.frames_done); end
        checks++; if (ifc.out_rows !== 36'h0) begin failures++; $display("FAIL areset_rows got=%0h exp=0", ifc.out_rows); end
        checks++; if (ifc.in_ready !== 1'b1) begin failures++; $display("FAIL areset_in_ready got=%0h exp=1", ifc.in_ready); end
        #2;
        ASYNCRESET = 1'b0;
    endtask

    task automatic test_wrap;
        tick();
        ifc.in_valid = 1'b1;
        ifc.in_row = 6'h2A;
        ifc.out_ready = 1'b1;
        repeat (255 * (DEPTH + NUM_OFF)) tick();
        checks++; if (ifc.frames_done !== 8'd255) begin failures++; $display("FAIL wrap_255 got=%0h exp=ff", ifc.frames_done); end
        checks++; if (ifc.in_ready !== 1'b1) begin failures++; $display("FAIL wrap_fill got=%0h exp=1", ifc.in_ready); end
        repeat (DEPTH + NUM_OFF) tick();
        checks++; if (ifc.frames_done !== 8'd0) begin failures++; $display("FAIL wrap_zero got=%0h exp=0", ifc.frames_done); end
        ifc.in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_backpressure();
        test_valid_toggle();
        test_flush_fill();
        test_flush_last();
        test_async_reset();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
